// File: rtl/rtc_cmd_sched_pkg.sv
// Shared encodings for the RTC command sequencer: register offsets, opcodes,
// RTC_CTL command values and the sequencer state/command types.
package rtc_cmd_sched_pkg;

    localparam logic [7:0]  RTC_CTL_ADDR  = 8'h00;
    localparam logic [7:0]  TICK_INC_ADDR = 8'h04;
    localparam logic [7:0]  SC_OFST_ADDR0 = 8'h08;
    localparam logic [7:0]  SC_OFST_ADDR1 = 8'h0C;
    localparam logic [7:0]  NS_OFST_ADDR  = 8'h10;

    localparam logic [31:0] RTC_CTL_LOAD  = 32'h1;
    localparam logic [31:0] RTC_CTL_CLEAR = 32'h2;

    localparam int unsigned NS_PER_SEC    = 1_000_000_000;

    typedef enum logic [1:0] {
        OP_SET_TIME = 2'd0,
        OP_CLEAR    = 2'd1,
        OP_SET_TICK = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LATCH,
        ST_W_SC0,
        ST_W_SC1,
        ST_W_NS,
        ST_GUARD,
        ST_W_CTL,
        ST_W_TICK,
        ST_DONE
    } state_e;

    typedef struct packed {
        op_e         op;
        logic [47:0] sc;
        logic [31:0] ns;
        logic [31:0] tick;
    } cmd_t;

    function automatic logic [31:0] ctl_value(input op_e op);
        return (op == OP_CLEAR) ? RTC_CTL_CLEAR : RTC_CTL_LOAD;
    endfunction

endpackage

// File: rtl/rtc_cmd_sched_arb.sv
// Two-way round-robin arbiter: host (bit 0) and servo (bit 1). The priority
// pointer only moves when both requesters compete.
module rtc_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    // 0: host wins the next tie, 1: servo wins the next tie
    logic ptr_q, ptr_d;

    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
                if (take_i) begin
                    ptr_d = ~ptr_q;
                end
            end
            default: gnt_o = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rtc_cmd_sched.sv
// Sequences host/servo commands into the RTC register block as atomic
// multi-write bursts, holding the RTC_CTL commit off near the second rollover.
module rtc_cmd_sched
    import rtc_cmd_sched_pkg::*;
#(
    parameter int unsigned GUARD_NS = 1000,
    parameter int unsigned NS_MAX   = 999_999_999
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        h_req_i,
    input  logic [1:0]  h_op_i,
    input  logic [47:0] h_sc_i,
    input  logic [31:0] h_ns_i,
    input  logic [31:0] h_tick_i,
    output logic        h_ack_o,
    output logic        h_err_o,

    input  logic        s_req_i,
    input  logic [1:0]  s_op_i,
    input  logic [47:0] s_sc_i,
    input  logic [31:0] s_ns_i,
    input  logic [31:0] s_tick_i,
    output logic        s_ack_o,
    output logic        s_err_o,

    input  logic [31:0] rtc_ns_i,

    output logic        reg_wr_o,
    output logic [7:0]  reg_addr_o,
    output logic [31:0] reg_wdata_o,
    input  logic        reg_rdy_i,

    output logic        busy_o,
    output logic [1:0]  gnt_o
);

    localparam logic [31:0] GUARD_START = 32'(NS_PER_SEC - GUARD_NS);
    localparam logic [31:0] NS_LIMIT    = 32'(NS_MAX);

    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic [1:0] own_q, own_d;
    logic       err_q, err_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       arb_take;
    cmd_t       h_cmd;
    cmd_t       s_cmd;

    function automatic logic cmd_rejected(input cmd_t c);
        return (c.op == OP_RSVD) || ((c.op == OP_SET_TIME) && (c.ns > NS_LIMIT));
    endfunction

    assign arb_req = {s_req_i, h_req_i};
    assign h_cmd   = '{op: op_e'(h_op_i), sc: h_sc_i, ns: h_ns_i, tick: h_tick_i};
    assign s_cmd   = '{op: op_e'(s_op_i), sc: s_sc_i, ns: s_ns_i, tick: s_tick_i};

    rtc_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (arb_req),
        .take_i (arb_take),
        .gnt_o  (arb_gnt)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        own_d       = own_q;
        err_d       = err_q;
        arb_take    = 1'b0;
        reg_wr_o    = 1'b0;
        reg_addr_o  = '0;
        reg_wdata_o = '0;
        h_ack_o     = 1'b0;
        h_err_o     = 1'b0;
        s_ack_o     = 1'b0;
        s_err_o     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (|arb_req) begin
                    arb_take = 1'b1;
                    own_d    = arb_gnt;
                    cmd_d    = arb_gnt[1] ? s_cmd : h_cmd;
                    state_d  = ST_LATCH;
                end
            end

            ST_LATCH: begin
                // A rejected command takes a second LATCH cycle so its ack
                // lands at the same latency as a single-write command.
                if (err_q) begin
                    state_d = ST_DONE;
                end else if (cmd_rejected(cmd_q)) begin
                    err_d = 1'b1;
                end else begin
                    case (cmd_q.op)
                        OP_SET_TIME: state_d = ST_W_SC0;
                        OP_CLEAR:    state_d = ST_GUARD;
                        OP_SET_TICK: state_d = ST_W_TICK;
                        default:     state_d = ST_DONE;
                    endcase
                end
            end

            ST_W_SC0: begin
                reg_wr_o    = 1'b1;
                reg_addr_o  = SC_OFST_ADDR0;
                reg_wdata_o = {16'h0, cmd_q.sc[47:32]};
                if (reg_rdy_i) begin
                    state_d = ST_W_SC1;
                end
            end

            ST_W_SC1: begin
                reg_wr_o    = 1'b1;
                reg_addr_o  = SC_OFST_ADDR1;
                reg_wdata_o = cmd_q.sc[31:0];
                if (reg_rdy_i) begin
                    state_d = ST_W_NS;
                end
            end

            ST_W_NS: begin
                reg_wr_o    = 1'b1;
                reg_addr_o  = NS_OFST_ADDR;
                reg_wdata_o = cmd_q.ns;
                if (reg_rdy_i) begin
                    state_d = ST_GUARD;
                end
            end

            ST_GUARD: begin
                if (rtc_ns_i < GUARD_START) begin
                    state_d = ST_W_CTL;
                end
            end

            // Once the commit is on the bus it is not withdrawn, whatever
            // rtc_ns_i does during a reg_rdy_i stall.
            ST_W_CTL: begin
                reg_wr_o    = 1'b1;
                reg_addr_o  = RTC_CTL_ADDR;
                reg_wdata_o = ctl_value(cmd_q.op);
                if (reg_rdy_i) begin
                    state_d = ST_DONE;
                end
            end

            ST_W_TICK: begin
                reg_wr_o    = 1'b1;
                reg_addr_o  = TICK_INC_ADDR;
                reg_wdata_o = cmd_q.tick;
                if (reg_rdy_i) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                h_ack_o = own_q[0];
                h_err_o = own_q[0] & err_q;
                s_ack_o = own_q[1];
                s_err_o = own_q[1] & err_q;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign gnt_o  = busy_o ? own_q : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            own_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            own_q   <= own_d;
            err_q   <= err_d;
        end
    end

endmodule
